// File: rtl/step_sequencer_pkg.sv
// step_sequencer_pkg: shared state encoding for the step sequencer
package step_sequencer_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_STEP_TCK = 3'd2,
        ST_STEP_SXR = 3'd3,
        ST_RUN_TEST = 3'd4,
        ST_HALTED   = 3'd5,
        ST_ABORT    = 3'd6
    } state_t;

endpackage

// File: rtl/step_sequencer_ram_clear_counter.sv
// step_sequencer_ram_clear_counter: walks the RAM address from 0 to CLEAR_LAST, restartable
module step_sequencer_ram_clear_counter #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] CLEAR_LAST = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  active,
    output logic                  done,
    output logic                  last
);

    assign last = active && (addr == CLEAR_LAST);

    // count while active; the cycle after the last write drops active and pulses done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr   <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            addr   <= '0;
            active <= 1'b1;
            done   <= 1'b0;
        end else begin
            addr   <= (active && !last) ? addr + ADDR_WIDTH'(1) : '0;
            active <= active && !last;
            done   <= last;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: turns decoder command pulses into sustained executor control and RAM clear
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] CLEAR_LAST = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  request_clear_mem,
    input  logic                  go_step_tck,
    input  logic                  go_step_sxr,
    input  logic                  go_step_test,
    input  logic                  test_halt,
    input  logic                  test_abort,
    input  logic                  tck_tick,
    input  logic                  sxr_done,
    input  logic                  test_done,
    output logic                  tck_enable,
    output logic                  exec_run,
    output logic                  exec_reset,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  clear_done,
    output logic                  busy,
    output logic [2:0]            state_out
);

    state_t state, state_nx, ret, ret_nx;
    logic   clr_last;
    logic   run_nx;

    step_sequencer_ram_clear_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CLEAR_LAST (CLEAR_LAST)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .start  (request_clear_mem),
        .addr   (ram_addr),
        .active (ram_we),
        .done   (clear_done),
        .last   (clr_last)
    );

    assign ram_data  = '0;
    assign state_out = state;
    assign run_nx    = state_nx inside {ST_STEP_TCK, ST_STEP_SXR, ST_RUN_TEST};

    // next state: clear beats everything, clear and abort states are uninterruptible by other pulses
    always_comb begin
        state_nx = state;
        ret_nx   = ret;
        if (request_clear_mem) begin
            state_nx = ST_CLEAR;
            ret_nx   = ST_IDLE;
        end else if (state == ST_CLEAR) begin
            state_nx = clr_last ? ST_IDLE : ST_CLEAR;
        end else if (state == ST_ABORT) begin
            state_nx = ST_IDLE;
        end else if (test_abort) begin
            state_nx = ST_ABORT;
            ret_nx   = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (go_step_test) begin
                        state_nx = ST_RUN_TEST;
                        ret_nx   = ST_IDLE;
                    end else if (go_step_sxr || go_step_tck) begin
                        state_nx = go_step_sxr ? ST_STEP_SXR : ST_STEP_TCK;
                        ret_nx   = state;
                    end
                end
                ST_STEP_TCK: state_nx = test_done ? ST_IDLE : (tck_tick ? ret : state);
                ST_STEP_SXR: state_nx = test_done ? ST_IDLE : (sxr_done ? ret : state);
                ST_RUN_TEST: state_nx = test_done ? ST_IDLE : (test_halt ? ST_HALTED : state);
                default:     state_nx = ST_IDLE;
            endcase
        end
    end

    // state register and registered control outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ret        <= ST_IDLE;
            tck_enable <= 1'b0;
            exec_run   <= 1'b0;
            exec_reset <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            ret        <= ret_nx;
            tck_enable <= run_nx;
            exec_run   <= run_nx;
            exec_reset <= request_clear_mem || (state_nx == ST_ABORT);
            busy       <= !(state_nx inside {ST_IDLE, ST_HALTED});
        end
    end

endmodule
